boot_loader: RTL and testbench

- Upstream feeder of the pipelined processor core.
- Accepts a byte stream over a valid/ready handshake and assembles the bytes big-endian into 32-bit instruction words.
- Writes each word into the instruction memory write port, holding the core in reset throughout the load.
- Releases core reset a fixed number of cycles after the last word is written, so the core begins fetching at PC 0.

---
 rtl/boot_loader_pkg.sv | 35 +++
 rtl/boot_loader_word_packer.sv | 50 +++++
 rtl/boot_loader.sv | 122 ++++++++++++
 tb/tb_boot_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader and the instruction memory it feeds.
package boot_loader_pkg;

   localparam int unsigned WORD_W              = 32;
   localparam int unsigned BYTE_W              = 8;
   localparam int unsigned LANE_W              = 2;
   localparam int unsigned SHIFT_W             = 5;
   localparam int unsigned DEFAULT_DEPTH_WORDS = 128;

   // Big-endian placement: the first byte of a word lands in the top lane.
   localparam int unsigned LANE0_SHIFT = 24;
   localparam int unsigned LANE1_SHIFT = 16;
   localparam int unsigned LANE2_SHIFT = 8;
   localparam int unsigned LANE3_SHIFT = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD,
      ST_RUN,
      ST_ERROR
   } state_t;

   function automatic logic [SHIFT_W-1:0] lane_shift(input logic [LANE_W-1:0] lane);
      logic [SHIFT_W-1:0] sh;
      unique case (lane)
         2'd0:    sh = SHIFT_W'(LANE0_SHIFT);
         2'd1:    sh = SHIFT_W'(LANE1_SHIFT);
         2'd2:    sh = SHIFT_W'(LANE2_SHIFT);
         default: sh = SHIFT_W'(LANE3_SHIFT);
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/boot_loader_word_packer.sv
// Packs accepted stream bytes big-endian into 32-bit words; a short final word is zero-padded.
module boot_loader_word_packer
   import boot_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data,
   input  logic              xfer,
   input  logic              last,
   input  logic              clear,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [LANE_W-1:0] lane;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] merged_c;

   // Lane 0 starts from zero so the unfilled low lanes of a short word read as zero.
   always_comb begin
      merged_c = (lane == LANE_W'(0)) ? '0 : acc;
      merged_c = merged_c | (WORD_W'(data) << lane_shift(lane));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane       <= '0;
         acc        <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            lane <= '0;
            acc  <= '0;
         end else if (xfer) begin
            if (lane == LANE_W'(3) || last) begin
               word       <= merged_c;
               word_valid <= 1'b1;
               lane       <= '0;
               acc        <= '0;
            end else begin
               acc  <= merged_c;
               lane <= lane + LANE_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/boot_loader.sv
// Streams a byte image into instruction memory while holding the core in reset, then releases it.
module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         s_valid,
   input  logic [BYTE_W-1:0]            s_data,
   input  logic                         s_last,
   output logic                         s_ready,
   input  logic                         reload,
   output logic                         wr_en,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic [WORD_W-1:0]            wr_data,
   output logic                         core_reset,
   output logic                         done,
   output logic                         err_overflow,
   output logic [$clog2(DEPTH_WORDS):0] word_count
);

   localparam int unsigned CNT_W  = $clog2(DEPTH_WORDS) + 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES) + 1;

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              xfer_c;
   logic              full_c;
   logic              pack_xfer_c;
   logic              pack_clear_c;

   // A word still in flight on wr_en already occupies its slot when judging overflow.
   always_comb begin
      xfer_c       = s_valid & s_ready;
      full_c       = (word_count + CNT_W'(wr_en)) == CNT_W'(DEPTH_WORDS);
      pack_xfer_c  = xfer_c && (state == ST_LOAD) && !full_c;
      pack_clear_c = (state == ST_IDLE);
   end

   boot_loader_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .data       (s_data),
      .xfer       (pack_xfer_c),
      .last       (s_last),
      .clear      (pack_clear_c),
      .word       (wr_data),
      .word_valid (wr_en)
   );

   // Address follows the write counter, which advances at the end of each wr_en cycle.
   assign wr_addr = ADDR_W'({word_count, 2'b00});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         s_ready      <= 1'b0;
         core_reset   <= 1'b1;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         word_count   <= '0;
         hold_cnt     <= '0;
      end else begin
         if (wr_en) begin
            word_count <= word_count + CNT_W'(1);
         end
         unique case (state)
            ST_IDLE: begin
               state        <= ST_LOAD;
               s_ready      <= 1'b1;
               word_count   <= '0;
               err_overflow <= 1'b0;
            end
            ST_LOAD: begin
               if (xfer_c) begin
                  if (full_c) begin
                     state        <= ST_ERROR;
                     err_overflow <= 1'b1;
                  end else if (s_last) begin
                     state    <= ST_HOLD;
                     s_ready  <= 1'b0;
                     hold_cnt <= '0;
                  end
               end
            end
            // Counting starts once the final write has left the wr_en cycle.
            ST_HOLD: begin
               if (!wr_en) begin
                  if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                     state      <= ST_RUN;
                     core_reset <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (reload) begin
                  state      <= ST_IDLE;
                  core_reset <= 1'b1;
                  done       <= 1'b0;
                  word_count <= '0;
               end
            end
            ST_ERROR: begin
               if (xfer_c && s_last) begin
                  state   <= ST_IDLE;
                  s_ready <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench: default-depth loader plus a 4-word instance for the overflow path.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        s_valid0 = 1'b0, s_last0 = 1'b0, reload0 = 1'b0;
   logic [7:0]  s_data0 = 8'h00;
   logic        s_ready0, wr_en0, core_reset0, done0, err0;
   logic [8:0]  wr_addr0;
   logic [31:0] wr_data0;
   logic [7:0]  word_count0;

   logic        s_valid4 = 1'b0, s_last4 = 1'b0, reload4 = 1'b0;
   logic [7:0]  s_data4 = 8'h00;
   logic        s_ready4, wr_en4, core_reset4, done4, err4;
   logic [8:0]  wr_addr4;
   logic [31:0] wr_data4;
   logic [2:0]  word_count4;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int t_last = 0;
   int bad4 = 0;
   int drop0 = 0;
   logic in_load = 1'b0;

   logic [31:0] wa0[$], wd0[$], wa4[$], wd4[$];

   always #5 clk = ~clk;

   boot_loader dut (
      .clk(clk), .reset(reset), .s_valid(s_valid0), .s_data(s_data0), .s_last(s_last0),
      .s_ready(s_ready0), .reload(reload0), .wr_en(wr_en0), .wr_addr(wr_addr0),
      .wr_data(wr_data0), .core_reset(core_reset0), .done(done0),
      .err_overflow(err0), .word_count(word_count0)
   );

   boot_loader #(.DEPTH_WORDS(4)) dut4 (
      .clk(clk), .reset(reset), .s_valid(s_valid4), .s_data(s_data4), .s_last(s_last4),
      .s_ready(s_ready4), .reload(reload4), .wr_en(wr_en4), .wr_addr(wr_addr4),
      .wr_data(wr_data4), .core_reset(core_reset4), .done(done4),
      .err_overflow(err4), .word_count(word_count4)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en0 === 1'b1) begin
         wa0.push_back(32'(wr_addr0));
         wd0.push_back(wr_data0);
      end
      if (wr_en4 === 1'b1) begin
         wa4.push_back(32'(wr_addr4));
         wd4.push_back(wr_data4);
      end
      if (core_reset4 !== 1'b1 || done4 !== 1'b0) bad4 <= bad4 + 1;
      if (in_load && s_ready0 !== 1'b1) drop0 <= drop0 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Presents one byte at a negedge, waits for the transfer edge, returns at the next negedge.
   task automatic send_byte(input int sel, input logic [7:0] b, input logic last, input int gap_pct);
      int n = 0;
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) @(negedge clk);
      if (sel == 0) begin s_valid0 = 1'b1; s_data0 = b; s_last0 = last; end
      else          begin s_valid4 = 1'b1; s_data4 = b; s_last4 = last; end
      while (((sel == 0) ? s_ready0 : s_ready4) !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("ready_wait", 32'((sel == 0) ? s_ready0 : s_ready4), 32'd1);
      @(posedge clk);
      @(negedge clk);
      t_last = cyc;
      if (sel == 0) begin s_valid0 = 1'b0; s_last0 = 1'b0; end
      else          begin s_valid4 = 1'b0; s_last4 = 1'b0; end
   endtask

   task automatic wait_run(input string tag);
      int n = 0;
      while (core_reset0 !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 32'(cyc - t_last), 32'd5);
      check({tag, "_done"}, 32'(done0), 32'd1);
   endtask

   task automatic do_reload(input string tag);
      reload0 = 1'b1;
      @(negedge clk);
      reload0 = 1'b0;
      check({tag, "_core_reset"}, 32'(core_reset0), 32'd1);
      check({tag, "_done"}, 32'(done0), 32'd0);
      check({tag, "_word_count"}, 32'(word_count0), 32'd0);
      @(negedge clk);
      wa0.delete();
      wd0.delete();
   endtask

   logic [7:0]  img [64];
   logic [31:0] exp_w;

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_s_ready", 32'(s_ready0), 32'd0);
      check("rst_wr_en", 32'(wr_en0), 32'd0);
      check("rst_wr_addr", 32'(wr_addr0), 32'd0);
      check("rst_wr_data", wr_data0, 32'd0);
      check("rst_core_reset", 32'(core_reset0), 32'd1);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      check("rst_word_count", 32'(word_count0), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("load_s_ready", 32'(s_ready0), 32'd1);

      // reload is ignored outside RUN
      reload0 = 1'b1;
      @(negedge clk);
      reload0 = 1'b0;
      @(negedge clk);
      check("reload_ignored_ready", 32'(s_ready0), 32'd1);
      check("reload_ignored_core_reset", 32'(core_reset0), 32'd1);

      // Overflow on the 4-word instance: 20 bytes 01..14
      for (int i = 0; i < 20; i++) begin
         send_byte(1, 8'(i + 1), i == 19, 0);
         if (i == 15) check("ovf_err_before17", 32'(err4), 32'd0);
         if (i == 16) check("ovf_err_after17", 32'(err4), 32'd1);
      end
      check("ovf_idle_err", 32'(err4), 32'd1);
      check("ovf_idle_ready", 32'(s_ready4), 32'd0);
      check("ovf_idle_word_count", 32'(word_count4), 32'd4);
      @(negedge clk);
      check("ovf_reload_ready", 32'(s_ready4), 32'd1);
      check("ovf_reload_err_cleared", 32'(err4), 32'd0);
      check("ovf_write_count", 32'(wa4.size()), 32'd4);
      check("ovf_w0", wd4[0], 32'h01020304);
      check("ovf_w3", wd4[3], 32'h0D0E0F10);
      check("ovf_a1", wa4[1], 32'd4);
      check("ovf_a3", wa4[3], 32'd12);
      check("ovf_core_reset_held", 32'(bad4), 32'd0);

      // Two-word image, back to back
      send_byte(0, 8'h01, 1'b0, 0);
      send_byte(0, 8'h00, 1'b0, 0);
      send_byte(0, 8'h00, 1'b0, 0);
      send_byte(0, 8'h00, 1'b0, 0);
      send_byte(0, 8'h82, 1'b0, 0);
      send_byte(0, 8'h10, 1'b0, 0);
      send_byte(0, 8'h20, 1'b0, 0);
      send_byte(0, 8'h05, 1'b1, 0);
      wait_run("img2");
      check("img2_writes", 32'(wa0.size()), 32'd2);
      check("img2_a0", wa0[0], 32'd0);
      check("img2_d0", wd0[0], 32'h01000000);
      check("img2_a1", wa0[1], 32'd4);
      check("img2_d1", wd0[1], 32'h82102005);
      check("img2_word_count", 32'(word_count0), 32'd2);

      // Three-byte image, zero padded
      do_reload("reload1");
      send_byte(0, 8'hAA, 1'b0, 0);
      send_byte(0, 8'hBB, 1'b0, 0);
      send_byte(0, 8'hCC, 1'b1, 0);
      wait_run("pad3");
      check("pad3_writes", 32'(wa0.size()), 32'd1);
      check("pad3_a0", wa0[0], 32'd0);
      check("pad3_d0", wd0[0], 32'hAABBCC00);
      check("pad3_word_count", 32'(word_count0), 32'd1);

      // s_last on the first byte
      do_reload("reload2");
      send_byte(0, 8'hBB, 1'b1, 0);
      wait_run("pad1");
      check("pad1_writes", 32'(wa0.size()), 32'd1);
      check("pad1_a0", wa0[0], 32'd0);
      check("pad1_d0", wd0[0], 32'hBB000000);

      // 64 bytes with random idle gaps
      do_reload("reload3");
      for (int i = 0; i < 64; i++) img[i] = 8'(i * 7 + 3);
      for (int i = 0; i < 64; i++) begin
         if (i == 63) in_load = 1'b0;
         send_byte(0, img[i], i == 63, 30);
         if (i == 0) in_load = 1'b1;
      end
      wait_run("gap64");
      check("gap64_writes", 32'(wa0.size()), 32'd16);
      check("gap64_ready_drops", 32'(drop0), 32'd0);
      for (int j = 0; j < 16 && j < wa0.size(); j++) begin
         exp_w = {img[4*j], img[4*j+1], img[4*j+2], img[4*j+3]};
         check($sformatf("gap64_a%0d", j), wa0[j], 32'(j * 4));
         check($sformatf("gap64_d%0d", j), wd0[j], exp_w);
      end

      // Asynchronous reset mid-load
      do_reload("reload4");
      for (int i = 0; i < 6; i++) send_byte(0, 8'(8'h40 + i), 1'b0, 0);
      #2 reset = 1'b0;
      #1;
      check("arst_s_ready", 32'(s_ready0), 32'd0);
      check("arst_wr_en", 32'(wr_en0), 32'd0);
      check("arst_wr_data", wr_data0, 32'd0);
      check("arst_core_reset", 32'(core_reset0), 32'd1);
      check("arst_word_count", 32'(word_count0), 32'd0);
      check("arst_done", 32'(done0), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      wa0.delete();
      wd0.delete();
      @(negedge clk);
      send_byte(0, 8'hDE, 1'b0, 0);
      send_byte(0, 8'hAD, 1'b0, 0);
      send_byte(0, 8'hBE, 1'b0, 0);
      send_byte(0, 8'hEF, 1'b1, 0);
      wait_run("fresh");
      check("fresh_writes", 32'(wa0.size()), 32'd1);
      check("fresh_a0", wa0[0], 32'd0);
      check("fresh_d0", wd0[0], 32'hDEADBEEF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
